// File: rtl/aes_192_stream_ctl.sv
// aes_192_stream_ctl
//   Flow-control shell around a free-running, non-stallable AES-192
//   encryption pipeline. Input blocks are accepted on a valid/ready
//   handshake and fed straight into the core. A valid/tag shift register
//   follows each accepted block through the core's fixed latency. The
//   resulting ciphertext is captured into a first-word-fall-through FIFO
//   and presented downstream on a second valid/ready handshake.
//
//   An occupancy counter covers blocks that are in the core and blocks
//   stored in the FIFO. Input is accepted only while this count is below
//   FIFO_DEPTH, so every result that leaves the core has a free FIFO slot.
//
// Parameters
//   LATENCY    : core register stages from state/key sample to core_out (2..64)
//   FIFO_DEPTH : output FIFO entries, power of two >= 2
//   TAG_W      : width of the user tag carried with each block
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake
//   in_state/in_key/in_tag: plaintext, 192-bit key, user tag
//   core_state/core_key   : combinational feed to the AES core
//   core_out              : ciphertext returned by the core
//   out_valid/out_ready   : output handshake
//   out_data/out_tag      : FIFO head ciphertext and its tag (0 when empty)
//   busy                  : any block accepted but not yet popped
//
// Optional feature (macro AES192_STREAM_STATS_EN)
//   stat_in_cnt, stat_out_cnt, stat_stall_cnt : 32-bit wrapping counters of
//   accepts, pops and stalled input cycles.

module aes_192_stream_ctl #(
  parameter int LATENCY    = 25,
  parameter int FIFO_DEPTH = 32,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_state,
  input  logic [191:0]     in_key,
  input  logic [TAG_W-1:0] in_tag,
  output logic [127:0]     core_state,
  output logic [191:0]     core_key,
  input  logic [127:0]     core_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
`ifdef AES192_STREAM_STATS_EN
  ,
  output logic [31:0]      stat_in_cnt,
  output logic [31:0]      stat_out_cnt,
  output logic [31:0]      stat_stall_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] DEPTH_C = OW'(FIFO_DEPTH);

  logic [OW-1:0]      occ;
  logic               accept;
  logic               pop;
  logic [LATENCY-1:0] vld_sr;
  logic [TAG_W-1:0]   tag_sr [LATENCY];
  logic [127:0]       mem_data [FIFO_DEPTH];
  logic [TAG_W-1:0]   mem_tag [FIFO_DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_wr;

  // The core samples its inputs every cycle whether or not a block is
  // accepted; only accepted cycles are tracked by the shift register.
  assign core_state = in_state;
  assign core_key   = in_key;

  // in_ready depends only on registered occupancy (and reset), never on
  // in_valid or out_ready, so there is no combinational handshake loop.
  assign in_ready = !reset && (occ < DEPTH_C);
  assign accept   = in_valid && in_ready;

  // The FIFO pointers carry one extra wrap bit to tell full from empty.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign fifo_wr    = vld_sr[LATENCY-1];

  // The head entry falls through to the outputs; the data is forced to zero
  // when the FIFO is empty so stale entries never show downstream.
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_data  = fifo_empty ? '0 : mem_data[rd_ptr[AW-1:0]];
  assign out_tag   = fifo_empty ? '0 : mem_tag[rd_ptr[AW-1:0]];
  assign busy      = (occ != '0);

  // Occupancy counts blocks in the core plus blocks in the FIFO. An accept
  // and a pop on the same edge cancel each other out.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Valid/tag shift register that mirrors the core pipeline. It shifts every
  // cycle because the core cannot stall; clearing it on reset discards any
  // blocks still inside the core.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_sr <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_sr[i] <= '0;
      end
    end else begin
      vld_sr    <= {vld_sr[LATENCY-2:0], accept};
      tag_sr[0] <= in_tag;
      for (int i = 1; i < LATENCY; i++) begin
        tag_sr[i] <= tag_sr[i-1];
      end
    end
  end

  // FIFO pointer update. A write and a pop may happen on the same edge,
  // even when the FIFO is full or empty; a write into an empty FIFO only
  // becomes visible on the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // FIFO storage has no reset; the read side masks it while empty.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_data[wr_ptr[AW-1:0]] <= core_out;
      mem_tag[wr_ptr[AW-1:0]]  <= tag_sr[LATENCY-1];
    end
  end

`ifdef AES192_STREAM_STATS_EN
  // Free-running event counters that wrap at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_in_cnt    <= '0;
      stat_out_cnt   <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (accept) begin
        stat_in_cnt <= stat_in_cnt + 32'd1;
      end
      if (pop) begin
        stat_out_cnt <= stat_out_cnt + 32'd1;
      end
      if (in_valid && !in_ready) begin
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
    end
  end
`endif

  // The occupancy bound means a result can never arrive at a full FIFO
  // that is not also being popped; catch it if that ever breaks.
  fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(fifo_wr && fifo_full && !pop));

  occ_in_range: assert property (@(posedge clk) disable iff (reset)
    occ <= DEPTH_C);

endmodule

// File: tb/tb_aes_192_stream_ctl.sv
// tb_aes_192_stream_ctl
//   Bench for aes_192_stream_ctl. A behavioural AES-192 core (full cipher
//   plus a LATENCY-deep delay line) drives core_out. A monitor pushes the
//   expected {ciphertext, tag} on every accept and compares on every pop.

module tb_aes_192_stream_ctl;

  localparam int LATENCY    = 25;
  localparam int FIFO_DEPTH = 32;
  localparam int TAG_W      = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_state;
  logic [191:0]     in_key;
  logic [TAG_W-1:0] in_tag;
  logic [127:0]     core_state;
  logic [191:0]     core_key;
  logic [127:0]     core_out;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
`ifdef AES192_STREAM_STATS_EN
  logic [31:0]      stat_in_cnt;
  logic [31:0]      stat_out_cnt;
  logic [31:0]      stat_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int acc_count = 0;
  int pop_count = 0;
  int stall_count = 0;
  logic [128+TAG_W-1:0] exp_q [$];

  logic [7:0]   sbox [256];
  logic [127:0] core_pipe [LATENCY];

  aes_192_stream_ctl #(
    .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_key(in_key), .in_tag(in_tag),
    .core_state(core_state), .core_key(core_key), .core_out(core_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .busy(busy)
`ifdef AES192_STREAM_STATS_EN
    ,
    .stat_in_cnt(stat_in_cnt), .stat_out_cnt(stat_out_cnt),
    .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse followed by the affine transform.
  initial begin : build_sbox
    logic [7:0] inv;
    logic [7:0] a8;
    logic [7:0] b8;
    for (int a = 0; a < 256; a++) begin
      a8  = 8'(a);
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        b8 = 8'(b);
        if (gmul(a8, b8) == 8'h01) inv = b8;
      end
      sbox[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  end

  function automatic logic [127:0] aes192(input logic [127:0] pt, input logic [191:0] key);
    logic [31:0]  w [52];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 6; i++) w[i] = key[191-32*i -: 32];
    rc = 8'h01;
    for (int i = 6; i < 52; i++) begin
      tmp = w[i-1];
      if (i % 6 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-6] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 12; r++) begin
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          t[4*c+rr] = sbox[s[4*((c+rr)%4)+rr]];
      if (r != 12) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Behavioural core: cipher at the input register, then a pure delay line
  // so the result sits on core_out after edge LATENCY-1.
  always @(posedge clk) begin
    core_pipe[0] <= aes192(core_state, core_key);
    for (int i = 1; i < LATENCY; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_out = core_pipe[LATENCY-1];

  // Scoreboard monitor, sampled on the falling edge for the coming rising edge.
  always @(negedge clk) begin : monitor
    logic [128+TAG_W-1:0] exp_v;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back({aes192(in_state, in_key), in_tag});
        acc_count++;
      end
      if (in_valid && !in_ready) stall_count++;
      if (out_valid && out_ready) begin
        pop_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL scoreboard_unexpected got data=%h tag=%h, required no output", out_data, out_tag);
        end else begin
          exp_v = exp_q.pop_front();
          if ({out_data, out_tag} !== exp_v) begin
            errors++;
            $display("[TB] FAIL scoreboard_data got data=%h tag=%h, required data=%h tag=%h",
                     out_data, out_tag, exp_v[128+TAG_W-1:TAG_W], exp_v[TAG_W-1:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_block(input logic [TAG_W-1:0] tag);
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_key   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    in_tag   = tag;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_state = '0; in_key = '0; in_tag = '0;
    tick(); tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got %b, required 0", in_ready); end
    reset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready got %b, required 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b, required 0", out_valid); end
    checks++;
    if (out_data !== 128'h0) begin errors++; $display("[TB] FAIL reset_out_data got %h, required 0", out_data); end
    checks++;
    if (out_tag !== '0) begin errors++; $display("[TB] FAIL reset_out_tag got %h, required 0", out_tag); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b, required 0", busy); end
`ifdef AES192_STREAM_STATS_EN
    checks++;
    if ({stat_in_cnt, stat_out_cnt, stat_stall_cnt} !== 96'h0) begin
      errors++; $display("[TB] FAIL reset_stats got %h %h %h, required 0", stat_in_cnt, stat_out_cnt, stat_stall_cnt);
    end
`endif
  endtask

  task automatic test_fips();
    int seen;
    seen = 0;
    out_ready = 1'b1;
    in_state  = 128'h00112233445566778899aabbccddeeff;
    in_key    = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    in_tag    = 4'd5;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL fips_busy got %b, required 1", busy); end
    for (int e = 1; e <= 3 * LATENCY; e++) begin
      tick();
      if (out_valid) begin seen = e; break; end
    end
    checks++;
    if (seen != LATENCY) begin errors++; $display("[TB] FAIL fips_latency got edge %0d, required %0d", seen, LATENCY); end
    checks++;
    if (out_data !== 128'hdda97ca4864cdfe06eaf70a0ec0d7191) begin
      errors++; $display("[TB] FAIL fips_data got %h, required dda97ca4864cdfe06eaf70a0ec0d7191", out_data);
    end
    checks++;
    if (out_tag !== 4'd5) begin errors++; $display("[TB] FAIL fips_tag got %h, required 5", out_tag); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL fips_drain got out_valid=%b busy=%b, required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_streaming();
    int drops;
    int base;
    drops = 0;
    base = pop_count;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive_block(TAG_W'(i));
      in_valid = 1'b1;
      if (!in_ready) drops++;
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 4 * LATENCY && pop_count != base + 100; c++) tick();
    checks++;
    if (drops != 0) begin errors++; $display("[TB] FAIL stream_in_ready got %0d stalls, required 0", drops); end
    checks++;
    if (pop_count - base != 100) begin errors++; $display("[TB] FAIL stream_count got %0d, required 100", pop_count - base); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL stream_leftover got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_back_pressure();
    int base_acc;
    int base_stall;
    int base_pop;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    base_acc = acc_count;
    base_stall = stall_count;
    for (int c = 0; c < 40; c++) begin
      drive_block(TAG_W'(c));
      in_valid = 1'b1;
      tick();
    end
    checks++;
    if (acc_count - base_acc != FIFO_DEPTH) begin
      errors++; $display("[TB] FAIL bp_accepts got %0d, required %0d", acc_count - base_acc, FIFO_DEPTH);
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready got %b, required 0", in_ready); end
    checks++;
    if (stall_count - base_stall != 40 - FIFO_DEPTH) begin
      errors++; $display("[TB] FAIL bp_stalls got %0d, required %0d", stall_count - base_stall, 40 - FIFO_DEPTH);
    end
`ifdef AES192_STREAM_STATS_EN
    checks++;
    if (stat_in_cnt !== 32'(FIFO_DEPTH)) begin errors++; $display("[TB] FAIL stat_in got %0d, required %0d", stat_in_cnt, FIFO_DEPTH); end
    checks++;
    if (stat_stall_cnt !== 32'(stall_count - base_stall)) begin
      errors++; $display("[TB] FAIL stat_stall got %0d, required %0d", stat_stall_cnt, stall_count - base_stall);
    end
    checks++;
    if (stat_out_cnt !== 32'd0) begin errors++; $display("[TB] FAIL stat_out got %0d, required 0", stat_out_cnt); end
`endif
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_out_valid got %b, required 1", out_valid); end
    base_pop = pop_count;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (pop_count - base_pop != 1) begin errors++; $display("[TB] FAIL bp_single_pop got %0d, required 1", pop_count - base_pop); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_reopen got %b, required 1", in_ready); end
    base_acc = acc_count;
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (acc_count - base_acc != 1) begin errors++; $display("[TB] FAIL bp_single_accept got %0d, required 1", acc_count - base_acc); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_reclose got %b, required 0", in_ready); end
`ifdef AES192_STREAM_STATS_EN
    checks++;
    if (stat_in_cnt !== 32'(FIFO_DEPTH + 1) || stat_out_cnt !== 32'd1) begin
      errors++; $display("[TB] FAIL stat_after_pop got in=%0d out=%0d, required in=%0d out=1", stat_in_cnt, stat_out_cnt, FIFO_DEPTH + 1);
    end
`endif
  endtask

  task automatic test_full_simultaneous();
    int max_occ;
    max_occ = exp_q.size();
    out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      drive_block(TAG_W'(c));
      in_valid = 1'b1;
      tick();
      if (exp_q.size() > max_occ) max_occ = exp_q.size();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 200 && (exp_q.size() != 0 || out_valid); c++) tick();
    checks++;
    if (max_occ > FIFO_DEPTH) begin errors++; $display("[TB] FAIL full_occ got %0d, required <= %0d", max_occ, FIFO_DEPTH); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL full_lost got %0d outstanding, required 0", exp_q.size()); end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL full_drain got busy=%b out_valid=%b, required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    int seen;
    int base_pop;
    bad = 0;
    seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_block(TAG_W'(i));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    base_pop = pop_count;
    for (int c = 0; c < 30; c++) begin
      if (out_valid) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || pop_count != base_pop) begin
      errors++; $display("[TB] FAIL reset_mid_out_valid got %0d valid cycles, required 0", bad);
    end
    drive_block(4'd9);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int e = 1; e <= 3 * LATENCY; e++) begin
      tick();
      if (out_valid) begin seen = e; break; end
    end
    checks++;
    if (seen != LATENCY) begin errors++; $display("[TB] FAIL reset_mid_latency got edge %0d, required %0d", seen, LATENCY); end
    tick();
    checks++;
    if (pop_count - base_pop != 1 || exp_q.size() != 0) begin
      errors++; $display("[TB] FAIL reset_mid_result got %0d pops, required 1", pop_count - base_pop);
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_streaming();
    test_back_pressure();
    test_full_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
